// File: rtl/jump_target_encoder.sv
// Sequential J/JAL instruction encoder with valid/ready handshakes on both sides.
// Optional saturating error counter is enabled by defining JENC_ERRCNT_EN.
module jump_target_encoder #(
  parameter logic [5:0] OPC_J   = 6'b000010,
  parameter logic [5:0] OPC_JAL = 6'b000011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] target,
  input  logic [31:0] pc_plus4,
  input  logic        link,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic        err_align,
  output logic        err_region
`ifdef JENC_ERRCNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENCODE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] tgt_q, tgt_d;
  logic [3:0]  pc_hi_q, pc_hi_d;
  logic        link_q, link_d;
  logic [31:0] instr_q, instr_d;
  logic        err_align_q, err_align_d;
  logic        err_region_q, err_region_d;

  // Only the region nibble of pc_plus4 matters; the low bits are deliberately dropped.
  logic unused_pc_low;
  assign unused_pc_low = ^pc_plus4[27:0];

  always_comb begin
    state_d      = state_q;
    tgt_d        = tgt_q;
    pc_hi_d      = pc_hi_q;
    link_d       = link_q;
    instr_d      = instr_q;
    err_align_d  = err_align_q;
    err_region_d = err_region_q;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          tgt_d   = target;
          pc_hi_d = pc_plus4[31:28];
          link_d  = link;
          state_d = ENCODE;
        end
      end
      ENCODE: begin
        instr_d      = {(link_q ? OPC_JAL : OPC_J), tgt_q[27:2]};
        err_align_d  = |tgt_q[1:0];
        err_region_d = (tgt_q[31:28] != pc_hi_q);
        state_d      = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      tgt_q        <= 32'h0;
      pc_hi_q      <= 4'h0;
      link_q       <= 1'b0;
      instr_q      <= 32'h0;
      err_align_q  <= 1'b0;
      err_region_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      pc_hi_q      <= pc_hi_d;
      link_q       <= link_d;
      instr_q      <= instr_d;
      err_align_q  <= err_align_d;
      err_region_q <= err_region_d;
    end
  end

  assign instr      = instr_q;
  assign err_align  = err_align_q;
  assign err_region = err_region_q;

`ifdef JENC_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;

  // Counted on the handoff so a result stuck under backpressure is counted once.
  always_comb begin
    err_count_d = err_count_q;
    if (state_q == HOLD && out_ready && (err_align_q | err_region_q) &&
        err_count_q != 8'hFF)
      err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_count_q <= 8'h00;
    else     err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_jump_target_encoder.sv
// Scoreboard bench for jump_target_encoder: driver pushes expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_jump_target_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] target = 32'h0;
  logic [31:0] pc_plus4 = 32'h0;
  logic        link = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] instr;
  logic        err_align;
  logic        err_region;
`ifdef JENC_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  jump_target_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .target(target), .pc_plus4(pc_plus4), .link(link),
    .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
    .err_align(err_align), .err_region(err_region)
`ifdef JENC_ERRCNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] tgt;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        ea;
    logic        er;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  logic rand_mode = 1'b0;
  logic ready_force = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Sole writer of out_ready, updated 2 time units after each rising edge.
  always @(posedge clk) begin
    #2;
    out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_force;
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("ready_valid_excl", {31'b0, in_ready & out_valid}, 32'h0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 32'h1, 32'h0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("instr", instr, e.instr);
          chk("err_align", {31'b0, err_align}, {31'b0, e.ea});
          chk("err_region", {31'b0, err_region}, {31'b0, e.er});
          if (!e.ea && !e.er)
            chk("round_trip", {e.pc[31:28], instr[25:0], 2'b00}, e.tgt);
          $display("result tgt=%h pc=%h instr=%h ea=%0d er=%0d", e.tgt, e.pc, instr,
                   err_align, err_region);
        end
      end
    end
  end

  // Entered and left at posedge+1; garbage on the inputs after acceptance.
  task automatic send(input logic [31:0] t, input logic [31:0] p, input logic l,
                      input logic [31:0] ei, input logic ea, input logic er,
                      input logic do_push);
    logic acc;
    int   n;
    exp_t e;
    target   = t;
    pc_plus4 = p;
    link     = l;
    in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("accept_timeout", 32'h0, 32'h1);
    if (acc && do_push) begin
      e.tgt = t; e.pc = p; e.instr = ei; e.ea = ea; e.er = er;
      q.push_back(e);
    end
    in_valid = 1'b0;
    target   = $urandom;
    pc_plus4 = $urandom;
    link     = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 32'h0);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] r_pc, r_tgt, r_bits, r_instr;
  logic        r_link, r_ea, r_er;
  logic [31:0] held;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", {31'b0, in_ready}, 32'h1);
    chk("reset_out_valid", {31'b0, out_valid}, 32'h0);
    chk("reset_instr", instr, 32'h0);
    chk("reset_flags", {30'b0, err_align, err_region}, 32'h0);
`ifdef JENC_ERRCNT_EN
    chk("reset_err_count", {24'b0, err_count}, 32'h0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Legal J, with latency check: ENCODE after the latching edge, HOLD one edge later.
    send(32'h0040_0100, 32'h0040_0008, 1'b0, 32'h0810_0040, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("latency_encode_no_valid", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    chk("latency_hold_valid", {31'b0, out_valid}, 32'h1);
    drain();

    // Reset while in ENCODE: the request is discarded.
    send(32'h0000_0200, 32'h0000_0004, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_in_ready", {31'b0, in_ready}, 32'h1);
    chk("rst_async_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_async_instr", instr, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_no_valid", {31'b0, out_valid}, 32'h0);
    end
    @(posedge clk);
    #1;

    // Legal JAL under 5 cycles of backpressure.
    ready_force = 1'b0;
    send(32'h0FFF_FFFC, 32'h0000_0004, 1'b1, 32'h0FFF_FFFF, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("bp_valid", {31'b0, out_valid}, 32'h1);
    chk("bp_instr", instr, 32'h0FFF_FFFF);
    held = instr;
    repeat (5) begin
      @(negedge clk);
      chk("bp_stable", instr, held);
      chk("bp_in_ready_low", {31'b0, in_ready}, 32'h0);
      chk("bp_valid_held", {31'b0, out_valid}, 32'h1);
    end
    @(posedge clk);
    #1;
    ready_force = 1'b1;
    drain();

    // Region error.
    send(32'h1000_0000, 32'h0000_0004, 1'b0, 32'h0800_0000, 1'b0, 1'b1, 1'b1);
    drain();
`ifdef JENC_ERRCNT_EN
    chk("err_count_region", {24'b0, err_count}, 32'h1);
`endif

    // Misaligned target.
    send(32'h0000_0102, 32'h0000_0004, 1'b0, 32'h0800_0040, 1'b1, 1'b0, 1'b1);
    drain();
`ifdef JENC_ERRCNT_EN
    chk("err_count_align", {24'b0, err_count}, 32'h2);
`endif

    // 260 region errors back to back; index field carries the request number.
    for (int i = 0; i < 260; i++)
      send(32'h2000_0000 | (i << 2), 32'h0000_0000, 1'b0, 32'h0800_0000 | i,
           1'b0, 1'b1, 1'b1);
    drain();
`ifdef JENC_ERRCNT_EN
    chk("err_count_saturated", {24'b0, err_count}, 32'hFF);
`endif

    // Random stream with random out_ready.
    rand_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      r_pc   = $urandom;
      r_bits = $urandom;
      r_link = 1'($urandom_range(0, 1));
      r_tgt  = {r_pc[31:28], r_bits[25:0], 2'b00};
      case ($urandom_range(0, 3))
        0: r_tgt[1:0] = 2'($urandom_range(1, 3));
        1: r_tgt[31:28] = r_pc[31:28] ^ 4'($urandom_range(1, 15));
        default: ;
      endcase
      r_instr = {(r_link ? 6'b000011 : 6'b000010), r_tgt[27:2]};
      r_ea    = (r_tgt[1:0] != 2'b00);
      r_er    = (r_tgt[31:28] != r_pc[31:28]);
      send(r_tgt, r_pc, r_link, r_instr, r_ea, r_er, 1'b1);
    end
    drain();
    rand_mode = 1'b0;
    repeat (4) @(negedge clk);
    chk("lost_results", q.size(), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
